result_readback_drain: RTL and testbench

//  Reads finished result rows from the results SRAM and serialises them to the host port, one partial sum per beat.
//  - Row width is MATRIX_SIZE x PARTIAL_SUM_BW; rows are the de-skewed systolic-array outputs.
//  - Output uses a valid/ready handshake.
//  - Sits between the results SRAM read port and the host/DMA side of the TPU top.

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/row_piso_serializer.sv | 41 ++++
 rtl/result_readback_drain.sv | 102 ++++++++++
 tb/tb_result_readback_drain.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU constants: drain FSM encoding and row geometry.
// Row width is always derived from beat width times lane count.
package tpu_pkg;

  localparam int ADDRESSSIZE_D = 10;
  localparam int PSB_D         = 20;
  localparam int MS_D          = 8;
  localparam int ROW_BW        = PSB_D * MS_D;
  localparam int LANE_W        = $clog2(MS_D);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  function automatic int row_bw(input int psb, input int ms);
    return psb * ms;
  endfunction

endpackage

// File: rtl/row_piso_serializer.sv
// Parallel-in/serial-out row register; lane 0 (LSBs) leaves first.
// Shifts one partial sum per accepted beat.
module row_piso_serializer
  import tpu_pkg::*;
#(
  parameter  int PSB    = PSB_D,
  parameter  int MS     = MS_D,
  localparam int RBW    = row_bw(PSB, MS),
  localparam int LW     = $clog2(MS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [RBW-1:0] i_row,
  input  logic           i_shift,
  output logic [PSB-1:0] o_data,
  output logic [LW-1:0]  o_lane,
  output logic           o_row_end
);

  logic [RBW-1:0] r_row;
  logic [LW-1:0]  r_lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row  <= '0;
      r_lane <= '0;
    end else if (i_load) begin
      r_row  <= i_row;
      r_lane <= '0;
    end else if (i_shift) begin
      r_row  <= r_row >> PSB;
      r_lane <= r_lane + 1'b1;
    end
  end

  assign o_data    = r_row[PSB-1:0];
  assign o_lane    = r_lane;
  assign o_row_end = (r_lane == LW'(MS - 1));

endmodule

// File: rtl/result_readback_drain.sv
// Drains result rows from the results SRAM to the host port,
// one partial sum per valid/ready beat.
module result_readback_drain
  import tpu_pkg::*;
#(
  parameter  int ADDRESSSIZE    = ADDRESSSIZE_D,
  parameter  int PARTIAL_SUM_BW = PSB_D,
  parameter  int MATRIX_SIZE    = MS_D,
  localparam int RBW            = row_bw(PARTIAL_SUM_BW, MATRIX_SIZE),
  localparam int LW             = $clog2(MATRIX_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDRESSSIZE-1:0]    base_addr,
  input  logic [ADDRESSSIZE:0]      num_rows,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDRESSSIZE-1:0]    rd_addr,
  input  logic [RBW-1:0]            rd_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [PARTIAL_SUM_BW-1:0] m_data,
  output logic [LW-1:0]             m_lane,
  output logic                      m_last
);

  logic [1:0]             r_state;
  logic [ADDRESSSIZE-1:0] r_addr;
  logic [ADDRESSSIZE:0]   r_rows_left;
  logic                   r_zero_done;

  logic w_hs;
  logic w_row_end;
  logic w_last_row;
  logic w_fin;
  logic w_idle_start;

  assign w_hs         = m_valid & m_ready;
  assign w_last_row   = (r_rows_left == (ADDRESSSIZE+1)'(1));
  assign w_fin        = w_hs & w_row_end & w_last_row;
  assign w_idle_start = (r_state == S_IDLE) & start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rows_left <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_idle_start & (num_rows == '0);
      unique case (r_state)
        S_IDLE: begin
          if (w_idle_start && num_rows != '0) begin
            r_addr      <= base_addr;
            r_rows_left <= num_rows;
            r_state     <= S_READ;
          end
        end
        S_READ: r_state <= S_CAPT;
        S_CAPT: r_state <= S_SEND;
        S_SEND: begin
          if (w_hs && w_row_end) begin
            if (w_last_row) begin
              r_state <= S_IDLE;
            end else begin
              // address wraps naturally at the top of the SRAM
              r_addr      <= r_addr + 1'b1;
              r_rows_left <= r_rows_left - 1'b1;
              r_state     <= S_READ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  row_piso_serializer #(
    .PSB (PARTIAL_SUM_BW),
    .MS  (MATRIX_SIZE)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .i_load    (r_state == S_CAPT),
    .i_row     (rd_data),
    .i_shift   (w_hs),
    .o_data    (m_data),
    .o_lane    (m_lane),
    .o_row_end (w_row_end)
  );

  assign rd_en   = (r_state == S_READ);
  assign rd_addr = rd_en ? r_addr : '0;
  assign m_valid = (r_state == S_SEND);
  assign m_last  = m_valid & w_row_end & w_last_row;
  // busy drops in the final handshake cycle so it never overlaps done
  assign busy    = (r_state != S_IDLE) & ~w_fin;
  assign done    = r_zero_done | w_fin;

endmodule

// File: tb/tb_result_readback_drain.sv
// Scoreboard bench for result_readback_drain with an SRAM model
// and a transfer-level reference model.
module tb_result_readback_drain;

  localparam int AS  = 10;
  localparam int PSB = 20;
  localparam int MS  = 8;
  localparam int RB  = PSB * MS;
  localparam int LW  = 3;
  localparam int NR  = 1 << AS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AS-1:0] base_addr = '0;
  logic [AS:0]   num_rows = '0;
  logic          busy, done, rd_en;
  logic [AS-1:0] rd_addr;
  logic [RB-1:0] rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [PSB-1:0] m_data;
  logic [LW-1:0] m_lane;
  logic          m_last;

  result_readback_drain dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_lane    (m_lane),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PSB-1:0] d;
    logic [LW-1:0]  l;
    logic           last;
  } beat_t;

  logic [RB-1:0] mem [NR];
  beat_t         bq[$];
  int            aq[$];
  int            checks = 0;
  int            errors = 0;
  int            n_hs = 0;
  int            rmode = 0;
  bit            zero_ok = 1'b0;
  bit            mon_en = 1'b0;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: rows base..base+rows-1 modulo SRAM depth, lanes LSB-first
  task automatic push_xfer(input int base, input int rows);
    for (int r = 0; r < rows; r++) begin
      int a;
      logic [RB-1:0] row;
      beat_t b;
      a = (base + r) % NR;
      row = mem[a];
      aq.push_back(a);
      for (int l = 0; l < MS; l++) begin
        b.d = row[l*PSB +: PSB];
        b.l = LW'(l);
        b.last = (r == rows - 1) && (l == MS - 1);
        bq.push_back(b);
      end
    end
  endtask

  task automatic do_start(input int base, input int rows, input bit model);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AS'(base);
    num_rows = (AS+1)'(rows);
    if (model) push_xfer(base, rows);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int c;
    c = 0;
    while ((bq.size() != 0 || busy) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= maxc) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats pending expected 0", nm, bq.size());
    end
    @(negedge clk);
    chk({nm, "_reads_left"}, 64'(aq.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    bit    pst;
    beat_t pb;
    beat_t e;
    pst = 1'b0;
    pb = '0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        pst = 1'b0;
        continue;
      end
      chk("done_busy_excl", 64'(done & busy), 64'd0);
      if (pst) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_hold", 64'({m_data, m_lane, m_last}), 64'(pb));
      end
      if (rd_en) begin
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd: got addr %0h expected no read", rd_addr);
        end else begin
          chk("rd_addr", 64'(rd_addr), 64'(aq.pop_front()));
        end
      end
      if (m_valid && m_ready) begin
        n_hs++;
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", m_data);
        end else begin
          e = bq.pop_front();
          chk("m_data", 64'(m_data), 64'(e.d));
          chk("m_lane", 64'(m_lane), 64'(e.l));
          chk("m_last", 64'(m_last), 64'(e.last));
          chk("done_on_last", 64'(done), 64'(e.last));
        end
      end else if (done && !zero_ok) begin
        checks++; errors++;
        $display("FAIL spurious_done: got 1 expected 0");
      end
      pst = m_valid && !m_ready;
      pb = {m_data, m_lane, m_last};
    end
  end

  initial begin
    int h0, c;
    for (int i = 0; i < NR; i++)
      for (int l = 0; l < MS; l++) mem[i][l*PSB +: PSB] = PSB'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 64'({busy, done, rd_en, rd_addr, m_valid, m_last}), 64'd0);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // two rows from address 5 with ready tied high
    h0 = n_hs;
    do_start(5, 2, 1'b1);
    wait_idle(200, "t1");
    chk("t1_beats", 64'(n_hs - h0), 64'd16);

    // stalled transfer of a hand-crafted row
    for (int l = 0; l < MS; l++) mem[5][l*PSB +: PSB] = 20'hABCDE;
    mem[5][3*PSB +: PSB] = 20'h00001;
    rmode = 1;
    h0 = n_hs;
    do_start(5, 1, 1'b1);
    wait_idle(200, "t2");
    chk("t2_beats", 64'(n_hs - h0), 64'd8);
    rmode = 0;

    // zero-row request
    zero_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AS'($urandom); num_rows = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t3_done_pulse", 64'(done), 64'd0);
    chk("t3_busy2", 64'(busy), 64'd0);
    zero_ok = 1'b0;

    // address wrap
    h0 = n_hs;
    do_start(NR - 1, 2, 1'b1);
    wait_idle(200, "t4");
    chk("t4_beats", 64'(n_hs - h0), 64'd16);

    // reset in the middle of the second of three rows
    h0 = n_hs;
    do_start(int'($urandom_range(0, NR - 1)), 3, 1'b1);
    c = 0;
    while (n_hs - h0 < 12 && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("t5_reach_lane4", 64'(c < 200), 64'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bq.delete();
    aq.delete();
    @(negedge clk);
    chk("t5_rst_outputs", 64'({m_valid, busy, done, rd_en}), 64'd0);
    @(negedge clk);
    chk("t5_rst_idle", 64'({busy, rd_en}), 64'd0);
    do_start(int'($urandom_range(0, NR - 1)), 2, 1'b1);
    wait_idle(200, "t5b");

    // start while busy is ignored
    h0 = n_hs;
    do_start(100, 2, 1'b1);
    c = 0;
    while (!m_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t6_reach_send", 64'(c < 50), 64'd1);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AS'(700); num_rows = (AS+1)'(5);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(300, "t6");
    chk("t6_beats", 64'(n_hs - h0), 64'd16);

    // randomized transfers under random backpressure
    rmode = 2;
    for (int k = 0; k < 10; k++) begin
      do_start(int'($urandom_range(0, NR - 1)), int'($urandom_range(1, 4)), 1'b1);
      wait_idle(600, "rand");
    end
    rmode = 0;

    // every row of the SRAM once
    h0 = n_hs;
    do_start(int'($urandom_range(0, NR - 1)), NR, 1'b1);
    wait_idle(12000, "full");
    chk("full_beats", 64'(n_hs - h0), 64'(NR * MS));

    chk("queues_empty", 64'(bq.size() + aq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
